// File: rtl/snake_input_scheduler.sv
// -----------------------------------------------------------------------------
// snake_input_scheduler
//
// Turns raw board button presses into the snake game's move stream.
//   - 2-FF synchroniser and debounce counter per button
//   - round-robin arbiter over debounced rising edges (pending mask)
//   - same-direction / reversal filter against the last accepted move
//   - small move queue; one entry consumed per i_step pulse
//
// Direction / button index encoding: 0 up, 1 right, 2 down, 3 left.
//
// Optional feature macro: SNAKE_INPUT_REVERSAL_FILTER_EN
//   defined     : a press opposite to the last accepted move is discarded and
//                 flagged on o_reject.
//   not defined : reversals are queued as ordinary turns; o_reject stays 0.
//
// Ports
//   clk        in   pixel clock
//   rst        in   synchronous active-high reset
//   i_up/i_down/i_left/i_right  in  raw asynchronous buttons, active-high
//   i_step     in   1-cycle pulse, game advances and consumes one queued move
//   i_restart  in   1-cycle pulse, new game: flush queue, direction back to right
//   o_dir      out  current move direction
//   o_count    out  number of queued moves
//   o_reject   out  1-cycle pulse, press discarded as reversal
//   o_drop     out  1-cycle pulse, press discarded because the queue was full
// -----------------------------------------------------------------------------
module snake_input_scheduler #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_up,
    input  logic                            i_down,
    input  logic                            i_left,
    input  logic                            i_right,
    input  logic                            i_step,
    input  logic                            i_restart,
    output logic [1:0]                      o_dir,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_reject,
    output logic                            o_drop
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] DIR_RIGHT = 2'd1;

    // Button vector ordered by direction code.
    logic [3:0] raw;
    assign raw = {i_left, i_down, i_right, i_up};

    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            stable_q, stable_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            rise;

    logic [3:0]            pending_q, pending_d;
    logic [1:0]            rr_q, rr_d;
    logic                  gnt_vld;
    logic [1:0]            gnt_dir;
    logic [1:0]            idx;
    logic [3:0]            gnt_mask;

    logic [1:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         count_q, count_d, count_after_pop;
    logic [1:0]            dir_q, dir_d;
    logic [1:0]            last_q, last_d;
    logic                  reject_q, reject_d;
    logic                  drop_q, drop_d;

    logic                  pop, push;
    logic                  is_same, is_rev, is_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Debounce: a change is taken only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement between the synchronised input and stable state.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise = stable_d & ~stable_q;
    end

    // Round-robin grant: first pending bit at or above rr_q, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_dir = rr_q;
        idx     = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!gnt_vld && pending_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_dir = idx;
            end
        end
        gnt_mask = gnt_vld ? (4'b0001 << gnt_dir) : 4'b0000;
    end

    // Move filter and queue control. Fullness is judged after this cycle's
    // pop so a full queue still accepts a press arriving with i_step.
    always_comb begin
        pop             = i_step && (count_q != '0);
        count_after_pop = count_q - CW'(pop);
        is_same         = (gnt_dir == last_q);
`ifdef SNAKE_INPUT_REVERSAL_FILTER_EN
        is_rev          = (gnt_dir == (last_q ^ 2'd2));
`else
        is_rev          = 1'b0;
`endif
        is_full         = (count_after_pop == CW'(FIFO_DEPTH));
        push            = gnt_vld && !is_same && !is_rev && !is_full;

        pending_d = (pending_q & ~gnt_mask) | rise;
        rr_d      = gnt_vld ? gnt_dir + 2'd1 : rr_q;
        rd_d      = pop  ? ptr_inc(rd_q) : rd_q;
        wr_d      = push ? ptr_inc(wr_q) : wr_q;
        dir_d     = pop  ? mem_q[rd_q] : dir_q;
        last_d    = push ? gnt_dir : last_q;
        count_d   = count_after_pop + CW'(push);
        reject_d  = gnt_vld && !is_same && is_rev;
        drop_d    = gnt_vld && !is_same && !is_rev && is_full;

        // Restart wins over step and push; debounced states are left alone so
        // a held button does not fire again.
        if (i_restart) begin
            push      = 1'b0;
            pending_d = '0;
            rr_d      = '0;
            rd_d      = '0;
            wr_d      = '0;
            dir_d     = DIR_RIGHT;
            last_d    = DIR_RIGHT;
            count_d   = '0;
            reject_d  = 1'b0;
            drop_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            dir_q     <= DIR_RIGHT;
            last_q    <= DIR_RIGHT;
            reject_q  <= 1'b0;
            drop_q    <= 1'b0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            last_q    <= last_d;
            reject_q  <= reject_d;
            drop_q    <= drop_d;
            if (push) begin
                mem_q[wr_q] <= gnt_dir;
            end
        end
    end

    assign o_dir    = dir_q;
    assign o_count  = count_q;
    assign o_reject = reject_q;
    assign o_drop   = drop_q;

endmodule

// File: tb/tb_snake_input_scheduler.sv
module tb_snake_input_scheduler;

    localparam int DEB   = 8;
    localparam int DEPTH = 2;
`ifdef SNAKE_INPUT_REVERSAL_FILTER_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       i_step, i_restart;
    logic [1:0] o_dir;
    logic [1:0] o_count;
    logic       o_reject, o_drop;

    always #5 clk = ~clk;

    snake_input_scheduler #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_up(btn[0]), .i_down(btn[2]), .i_left(btn[3]), .i_right(btn[1]),
        .i_step(i_step), .i_restart(i_restart),
        .o_dir(o_dir), .o_count(o_count), .o_reject(o_reject), .o_drop(o_drop)
    );

    int total = 0;
    int bad   = 0;
    int rej_cnt = 0, drop_cnt = 0;
    int exp_rej = 0, exp_drop = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mdl_dir, mdl_last;
    logic [1:0] e;

    always @(posedge clk) begin
        if (o_reject) rej_cnt <= rej_cnt + 1;
        if (o_drop)   drop_cnt <= drop_cnt + 1;
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference behaviour for one granted press, no step in the same cycle.
    task automatic model_press(input logic [1:0] d);
        if (d == mdl_last) begin
        end else if (REV_EN && d == (mdl_last ^ 2'd2)) begin
            exp_rej++;
        end else if (exp_q.size() >= DEPTH) begin
            exp_drop++;
        end else begin
            exp_q.push_back(d);
            mdl_last = d;
        end
    endtask

    task automatic press_one(input int d);
        btn[d] = 1'b1;
        clk_n(12);
        btn[d] = 1'b0;
        clk_n(12);
    endtask

    task automatic do_step(output logic [1:0] ed);
        i_step = 1'b1;
        clk_n(1);
        i_step = 1'b0;
        if (exp_q.size() > 0) mdl_dir = exp_q.pop_front();
        ed = mdl_dir;
    endtask

    task automatic do_restart(input bit with_step);
        i_restart = 1'b1;
        i_step    = with_step;
        clk_n(1);
        i_restart = 1'b0;
        i_step    = 1'b0;
        exp_q.delete();
        mdl_dir  = 2'd1;
        mdl_last = 2'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = '0; i_step = 1'b0; i_restart = 1'b0;
        mdl_dir = 2'd1; mdl_last = 2'd1;
        clk_n(3);
        rst = 1'b0;
        total++; if (o_dir !== 2'd1) begin bad++; $display("FAIL reset_dir got=%0d exp=1", o_dir); end
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        total++; if (o_reject !== 1'b0) begin bad++; $display("FAIL reset_reject got=%b exp=0", o_reject); end
        total++; if (o_drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", o_drop); end
        clk_n(2);
    endtask

    task automatic test_debounce();
        for (int i = 0; i < 7; i++) begin
            btn[2] = ~btn[2];
            if (i < 6) clk_n(3);
        end
        model_press(2'd2);
        clk_n(10);
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL deb_early got=%0d exp=0", o_count); end
        clk_n(1);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL deb_push got=%0d exp=%0d", o_count, exp_q.size()); end
        clk_n(20);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL deb_held got=%0d exp=%0d", o_count, exp_q.size()); end
        btn[2] = 1'b0;
        clk_n(12);
        do_step(e);
        total++; if (o_dir !== e) begin bad++; $display("FAIL deb_dir got=%0d exp=%0d", o_dir, e); end
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL deb_cnt_after_step got=%0d exp=%0d", o_count, exp_q.size()); end
    endtask

    task automatic test_round_robin();
        do_restart(1'b0);
        btn[0] = 1'b1; btn[3] = 1'b1;
        model_press(2'd0);
        model_press(2'd3);
        clk_n(11);
        total++; if (o_count !== 2'd1) begin bad++; $display("FAIL rr_first got=%0d exp=1", o_count); end
        clk_n(1);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rr_second got=%0d exp=%0d", o_count, exp_q.size()); end
        btn[0] = 1'b0; btn[3] = 1'b0;
        clk_n(12);
        do_step(e);
        total++; if (o_dir !== e) begin bad++; $display("FAIL rr_step1 got=%0d exp=%0d", o_dir, e); end
        do_step(e);
        total++; if (o_dir !== e) begin bad++; $display("FAIL rr_step2 got=%0d exp=%0d", o_dir, e); end
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rr_drained got=%0d exp=%0d", o_count, exp_q.size()); end
    endtask

    task automatic test_reversal();
        do_restart(1'b0);
        press_one(3);
        model_press(2'd3);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rev_count got=%0d exp=%0d", o_count, exp_q.size()); end
        total++; if (rej_cnt !== exp_rej) begin bad++; $display("FAIL rev_reject_pulses got=%0d exp=%0d", rej_cnt, exp_rej); end
        do_restart(1'b0);
        press_one(1);
        model_press(2'd1);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL same_count got=%0d exp=%0d", o_count, exp_q.size()); end
        total++; if (rej_cnt !== exp_rej) begin bad++; $display("FAIL same_reject_pulses got=%0d exp=%0d", rej_cnt, exp_rej); end
        total++; if (o_dir !== 2'd1) begin bad++; $display("FAIL same_dir got=%0d exp=1", o_dir); end
    endtask

    task automatic test_full_drop();
        do_restart(1'b0);
        press_one(0); model_press(2'd0);
        press_one(3); model_press(2'd3);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL full_count got=%0d exp=%0d", o_count, exp_q.size()); end
        press_one(2); model_press(2'd2);
        total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL full_drop_pulses got=%0d exp=%0d", drop_cnt, exp_drop); end
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL full_after_drop got=%0d exp=%0d", o_count, exp_q.size()); end
        // Grant of down lands in the same cycle as the step.
        btn[2] = 1'b1;
        clk_n(10);
        i_step = 1'b1;
        clk_n(1);
        i_step = 1'b0;
        e = exp_q.pop_front();
        mdl_dir = e;
        model_press(2'd2);
        total++; if (o_dir !== e) begin bad++; $display("FAIL popush_dir got=%0d exp=%0d", o_dir, e); end
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL popush_count got=%0d exp=%0d", o_count, exp_q.size()); end
        btn[2] = 1'b0;
        clk_n(12);
        total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL popush_no_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        do_step(e);
        total++; if (o_dir !== e) begin bad++; $display("FAIL full_step1 got=%0d exp=%0d", o_dir, e); end
        do_step(e);
        total++; if (o_dir !== e) begin bad++; $display("FAIL full_step2 got=%0d exp=%0d", o_dir, e); end
    endtask

    task automatic test_restart_held();
        do_restart(1'b0);
        btn[0] = 1'b1;
        clk_n(12);
        model_press(2'd0);
        press_one(3); model_press(2'd3);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rst_pre_count got=%0d exp=%0d", o_count, exp_q.size()); end
        do_restart(1'b1);
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", o_count); end
        total++; if (o_dir !== mdl_dir) begin bad++; $display("FAIL rst_dir got=%0d exp=%0d", o_dir, mdl_dir); end
        clk_n(30);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rst_held_refire got=%0d exp=%0d", o_count, exp_q.size()); end
        btn[0] = 1'b0;
        clk_n(12);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rst_release got=%0d exp=%0d", o_count, exp_q.size()); end
        press_one(0); model_press(2'd0);
        total++; if (o_count !== 2'(exp_q.size())) begin bad++; $display("FAIL rst_repress got=%0d exp=%0d", o_count, exp_q.size()); end
        do_step(e);
        total++; if (o_dir !== e) begin bad++; $display("FAIL rst_repress_dir got=%0d exp=%0d", o_dir, e); end
        total++; if (rej_cnt !== exp_rej) begin bad++; $display("FAIL final_reject_pulses got=%0d exp=%0d", rej_cnt, exp_rej); end
        total++; if (drop_cnt !== exp_drop) begin bad++; $display("FAIL final_drop_pulses got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_round_robin();
        test_reversal();
        test_full_drop();
        test_restart_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
